stopwatch_core: RTL

//  Time-keeping core of the stopwatch. Consumes the single-cycle 10 ms tick from
//  the clock divider and keeps a 4-digit BCD count SS.hh (00.00-99.99 s).

---
 rtl/stopwatch_core.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_core.sv
// Stopwatch time base: synchronises the buttons, runs the IDLE/RUN/PAUSE/LAP FSM and keeps a BCD SS.hh count.
// Latency: button action lands SYNC_STAGES+1 clk edges after the raw rising edge; count and display update on the tick edge.
// Backpressure: none; every tick_10ms high cycle in RUN/LAP counts, and each button press yields one request.
module stopwatch_core #(
    parameter int SYNC_STAGES = 2,
    parameter int SATURATE    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_10ms,
    input  logic        btn_start_stop,
    input  logic        btn_lap,
    input  logic        btn_clear,
    output logic [15:0] disp_bcd,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    // Four BCD digits, most significant first, matching the display bus order.
    typedef struct packed {
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
        logic [3:0] hund_tens;
        logic [3:0] hund_ones;
    } bcd_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_LAP   = 2'd3;

    localparam bcd_t BCD_ZERO = '0;
    localparam bcd_t BCD_MAX  = '{sec_tens: 4'd9, sec_ones: 4'd9,
                                  hund_tens: 4'd9, hund_ones: 4'd9};

    // ------------------------------------------------------------------
    // Button synchronisers and rising-edge detectors
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] lap_sync;
    logic [SYNC_STAGES-1:0] clr_sync;
    logic                   ss_prev;
    logic                   lap_prev;
    logic                   clr_prev;
    logic                   ss_req;
    logic                   lap_req;
    logic                   clr_req;

    // Shift each raw button through its synchroniser and keep one more flop for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ss_sync  <= '0;
            lap_sync <= '0;
            clr_sync <= '0;
            ss_prev  <= 1'b0;
            lap_prev <= 1'b0;
            clr_prev <= 1'b0;
        end else begin
            ss_sync  <= {ss_sync[SYNC_STAGES-2:0],  btn_start_stop};
            lap_sync <= {lap_sync[SYNC_STAGES-2:0], btn_lap};
            clr_sync <= {clr_sync[SYNC_STAGES-2:0], btn_clear};
            ss_prev  <= ss_sync[SYNC_STAGES-1];
            lap_prev <= lap_sync[SYNC_STAGES-1];
            clr_prev <= clr_sync[SYNC_STAGES-1];
        end
    end

    // A request is the first cycle a synchronised button is seen high; holding gives one request.
    assign ss_req  = ss_sync[SYNC_STAGES-1]  & ~ss_prev;
    assign lap_req = lap_sync[SYNC_STAGES-1] & ~lap_prev;
    assign clr_req = clr_sync[SYNC_STAGES-1] & ~clr_prev;

    // ------------------------------------------------------------------
    // BCD increment with ripple carry; digits never leave 0-9
    // ------------------------------------------------------------------
    function automatic bcd_t bcd_inc(input bcd_t v);
        bcd_t r;
        r = v;
        if (v.hund_ones != 4'd9) begin
            r.hund_ones = v.hund_ones + 4'd1;
        end else begin
            r.hund_ones = 4'd0;
            if (v.hund_tens != 4'd9) begin
                r.hund_tens = v.hund_tens + 4'd1;
            end else begin
                r.hund_tens = 4'd0;
                if (v.sec_ones != 4'd9) begin
                    r.sec_ones = v.sec_ones + 4'd1;
                end else begin
                    r.sec_ones = 4'd0;
                    if (v.sec_tens != 4'd9) begin
                        r.sec_tens = v.sec_tens + 4'd1;
                    end else begin
                        r.sec_tens = 4'd0;
                    end
                end
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State, live count, display and flags
    // ------------------------------------------------------------------
    logic [1:0] state;
    logic [1:0] state_n;
    bcd_t       cnt;
    bcd_t       cnt_n;
    bcd_t       disp_q;
    bcd_t       disp_n;
    logic       ovf_n;
    logic       cnt_inc;

    // Next count and state: the tick is judged against the current state, then requests
    // are applied with clear > start_stop > lap.
    always_comb begin
        cnt_n   = cnt;
        ovf_n   = overflow;
        state_n = state;
        cnt_inc = tick_10ms && ((state == ST_RUN) || (state == ST_LAP));

        if (cnt_inc) begin
            if (cnt == BCD_MAX) begin
                ovf_n = 1'b1;
                if (SATURATE == 0) begin
                    cnt_n = BCD_ZERO;
                end
            end else begin
                cnt_n = bcd_inc(cnt);
            end
        end

        if (clr_req) begin
            state_n = ST_IDLE;
            cnt_n   = BCD_ZERO;
            ovf_n   = 1'b0;
        end else if (ss_req) begin
            case (state)
                ST_IDLE:  state_n = ST_RUN;
                ST_RUN:   state_n = ST_PAUSE;
                ST_PAUSE: state_n = ST_RUN;
                ST_LAP:   state_n = ST_PAUSE;
                default:  state_n = ST_IDLE;
            endcase
        end else if (lap_req) begin
            case (state)
                ST_RUN:  state_n = ST_LAP;
                ST_LAP:  state_n = ST_RUN;
                default: state_n = state;
            endcase
        end
    end

    // Display freezes only while staying in LAP; on LAP entry it captures the count
    // as updated on that same edge, otherwise it tracks the count with no lag.
    always_comb begin
        disp_n = cnt_n;
        if ((state == ST_LAP) && (state_n == ST_LAP)) begin
            disp_n = disp_q;
        end
    end

    // All outputs are registered from the next-state values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= BCD_ZERO;
            disp_q     <= BCD_ZERO;
            overflow   <= 1'b0;
            running    <= 1'b0;
            lap_active <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            disp_q     <= disp_n;
            overflow   <= ovf_n;
            running    <= (state_n == ST_RUN) || (state_n == ST_LAP);
            lap_active <= (state_n == ST_LAP);
        end
    end

    assign disp_bcd = disp_q;

endmodule
